muldiv_control: RTL and testbench

MULDIV_CONTROL -- requirements
Module: muldiv_control

---
 rtl/muldiv_control.sv | 114 +++++++++++
 tb/tb_muldiv_control.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_control.sv
// muldiv_control: sequences a 32-cycle multiply/divide unit and owns the
// HI/LO result registers plus the MFHI/MFLO read path.
module muldiv_control #(
    parameter logic [5:0] MULTU = 6'b011001,
    parameter logic [5:0] DIVU  = 6'b011011,
    parameter logic [5:0] MFHI  = 6'b010000,
    parameter logic [5:0] MFLO  = 6'b010010,
    parameter logic [5:0] OUT   = 6'b111111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [5:0]  funct,
    input  logic [63:0] md_result,
    output logic        md_reset,
    output logic [5:0]  md_signal,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data,
    output logic        rd_valid
);

    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

    state_t     state, state_nxt;
    logic [5:0] op_q;
    logic [4:0] cnt;
    logic       start;

    // Only arithmetic codes start an operation; everything else in IDLE is a no-op
    // apart from the HI/LO reads handled below.
    assign start = req && (state == IDLE) && (funct == MULTU || funct == DIVU);

    // State register, operand latch and the RUN cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            op_q  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (start)
                op_q <= funct;
            if (state == INIT)
                cnt <= '0;
            else if (state == RUN)
                cnt <= cnt + 5'd1;
        end
    end

    // Next state and per-cycle drive to the arithmetic unit
    always_comb begin
        state_nxt = state;
        md_reset  = 1'b0;
        md_signal = 6'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = INIT;
            INIT: begin
                md_reset  = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                md_signal = op_q;
                if (cnt == 5'd31) state_nxt = DONE;
            end
            DONE: begin
                md_signal = OUT;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Reset must also clear the arithmetic unit and suppress any done pulse
        if (reset) begin
            md_reset  = 1'b1;
            md_signal = 6'b0;
            done      = 1'b0;
        end
    end

    assign busy = (state != IDLE);

    // HI/LO capture at the end of DONE; md_result is not looked at otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state == DONE) begin
            hi <= md_result[63:32];
            lo <= md_result[31:0];
        end
    end

    // MFHI/MFLO read port: one-cycle valid, data held between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (req && state == IDLE && funct == MFHI) begin
                rd_data  <= hi;
                rd_valid <= 1'b1;
            end else if (req && state == IDLE && funct == MFLO) begin
                rd_data  <= lo;
                rd_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_control.sv
// tb_muldiv_control: directed checks of muldiv_control against a small
// behavioural model of the arithmetic unit.
module tb_muldiv_control;

    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_OUT   = 6'b111111;
    localparam logic [63:0] JUNK   = 64'hDEAD_BEEF_0BAD_F00D;

    logic        clk = 0;
    logic        reset = 0;
    logic        req = 0;
    logic [5:0]  funct = 0;
    logic [63:0] md_result;
    logic        md_reset;
    logic [5:0]  md_signal;
    logic        busy, done, rd_valid;
    logic [31:0] hi, lo, rd_data;

    int n_cmp = 0, n_bad = 0;

    muldiv_control dut (
        .clk(clk), .reset(reset), .req(req), .funct(funct),
        .md_result(md_result), .md_reset(md_reset), .md_signal(md_signal),
        .busy(busy), .done(done), .hi(hi), .lo(lo),
        .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    // Arithmetic unit model: result valid only after exactly 32 op cycles
    logic [63:0] mval = 0;
    int mcnt = 0;
    always @(posedge clk) begin
        if (md_reset) mcnt <= 0;
        else if ((md_signal == F_MULTU || md_signal == F_DIVU) && mcnt < 40) mcnt <= mcnt + 1;
    end
    assign md_result = (mcnt == 32) ? mval : JUNK;

    // Activity monitor sampled on the falling edge
    int cyc = 0, n_rst = 0, n_op = 0, n_out = 0, n_done = 0, t_done = 0, t_prev = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (md_reset && !reset) n_rst = n_rst + 1;
        if (md_signal == F_MULTU || md_signal == F_DIVU) n_op = n_op + 1;
        if (md_signal == F_OUT) n_out = n_out + 1;
        if (done) begin
            n_done = n_done + 1;
            t_prev = t_done;
            t_done = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clr_mon();
        n_rst = 0; n_op = 0; n_out = 0; n_done = 0;
    endtask

    // Pulse a request for one cycle; returns #1 after the accepting edge
    task automatic issue(input logic [5:0] f);
        req = 1; funct = f;
        tick();
        req = 0; funct = 0;
    endtask

    // Count edges until busy drops, bounded
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    int n;
    logic [31:0] hi_s, lo_s, rd_s;

    initial begin
        // Reset state
        reset = 1;
        tick(); tick();
        @(negedge clk);
        chk("rst_md_reset", md_reset, 1);
        chk("rst_md_signal", md_signal, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hilo", {hi, lo}, 0);
        chk("rst_rd", {rd_valid, rd_data}, 0);
        @(posedge clk); #1;
        reset = 0;
        tick();

        // MULTU with result 15
        clr_mon();
        mval = 64'h0000_0000_0000_000F;
        issue(F_MULTU);
        chk("mul_busy_e0", busy, 1);
        wait_idle(n);
        chk("mul_latency", n, 34);
        chk("mul_hi", hi, 0);
        chk("mul_lo", lo, 15);
        chk("mul_md_reset_cycles", n_rst, 1);
        chk("mul_run_cycles", n_op, 32);
        chk("mul_out_cycles", n_out, 1);
        chk("mul_done_pulses", n_done, 1);
        @(negedge clk);
        chk("idle_md_signal", md_signal, 0);
        chk("idle_md_reset", md_reset, 0);

        // DIVU then reads
        tick();
        mval = 64'h0000_0002_0000_0007;
        issue(F_DIVU);
        wait_idle(n);
        chk("div_latency", n, 34);
        chk("div_hi", hi, 32'h2);
        chk("div_lo", lo, 32'h7);
        issue(F_MFHI);
        chk("mfhi_valid", rd_valid, 1);
        chk("mfhi_data", rd_data, 2);
        tick();
        chk("mfhi_valid_drop", rd_valid, 0);
        chk("mfhi_data_hold", rd_data, 2);
        issue(F_MFLO);
        chk("mflo_valid", rd_valid, 1);
        chk("mflo_data", rd_data, 7);
        tick();
        chk("mflo_valid_drop", rd_valid, 0);

        // Unknown function code in IDLE
        issue(6'b100000);
        chk("bad_busy", busy, 0);
        chk("bad_md_signal", md_signal, 0);
        chk("bad_rd_valid", rd_valid, 0);
        chk("bad_hilo", {hi, lo}, 64'h0000_0002_0000_0007);
        chk("bad_rd_data", rd_data, 7);

        // Request while busy at RUN cycle 5 (RUN cnt k spans E(k+1)..E(k+2))
        clr_mon();
        mval = 64'hAAAA_BBBB_CCCC_DDDD;
        issue(F_MULTU);
        repeat (5) tick();
        issue(F_MULTU);
        n = 6;
        begin
            int m;
            wait_idle(m);
            n = n + m;
        end
        chk("busyreq_latency", n, 34);
        chk("busyreq_run_cycles", n_op, 32);
        chk("busyreq_done_pulses", n_done, 1);
        chk("busyreq_hilo", {hi, lo}, 64'hAAAA_BBBB_CCCC_DDDD);
        tick();
        chk("busyreq_not_queued", busy, 0);

        // MFHI while busy is ignored
        issue(F_MULTU);
        rd_s = rd_data;
        issue(F_MFHI);
        chk("busy_mfhi_valid", rd_valid, 0);
        chk("busy_mfhi_data", rd_data, rd_s);
        // Reset at RUN cycle 10: edges so far after E0 = 1, need to reach E11
        clr_mon();
        repeat (9) tick();
        reset = 1; req = 1; funct = F_MULTU;
        @(negedge clk);
        chk("abort_md_reset", md_reset, 1);
        chk("abort_md_signal", md_signal, 0);
        chk("abort_done", done, 0);
        @(posedge clk); #1;
        reset = 0; req = 0; funct = 0;
        chk("abort_busy", busy, 0);
        chk("abort_hilo", {hi, lo}, 0);
        repeat (30) tick();
        chk("abort_no_done", n_done, 0);
        chk("abort_still_idle", busy, 0);

        // Back-to-back MULTU
        clr_mon();
        mval = 64'h1111_2222_3333_4444;
        issue(F_MULTU);
        wait_idle(n);
        chk("b2b1_latency", n, 34);
        chk("b2b1_hilo", {hi, lo}, 64'h1111_2222_3333_4444);
        mval = 64'h5555_6666_7777_8888;
        issue(F_MULTU);
        chk("b2b2_accepted", busy, 1);
        wait_idle(n);
        chk("b2b2_latency", n, 34);
        chk("b2b2_hilo", {hi, lo}, 64'h5555_6666_7777_8888);
        chk("b2b_done_pulses", n_done, 2);
        chk("b2b_spacing", t_done - t_prev, 35);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
